// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sequencer sharing one SPI byte engine among N_REQ requesters
// Owns per-requester chip select, holds grant across a multi-byte transaction, aborts on owner stall.
module spi_txn_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int IDLE_TMO = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [N_REQ-1:0]        txn_abort,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_tx,
  input  logic                    eng_done,
  input  logic [DATA_W-1:0]       eng_rx,
  output logic [N_REQ-1:0]        spi_cs_n,
  output logic [N_REQ-1:0]        grant
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);
  localparam logic [15:0] TMO_END   = 16'(IDLE_TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_XFER, S_GAP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [15:0]        cnt;
  logic               last_q;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   rr_next;
  logic               accept;
  logic [DATA_W-1:0]  owner_data;
  int                 pick_j;

  assign req_ready  = (state == S_ISSUE) ? grant : '0;
  assign accept     = (state == S_ISSUE) && req_valid[owner];
  assign owner_data = req_data[int'(owner)*DATA_W +: DATA_W];
  assign pick_oh    = N_REQ'(1) << pick_idx;
  assign rr_next    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // First requesting index at or after the round-robin pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_j = (int'(rr_ptr) + k) % N_REQ;
      if (!pick_found && req_valid[pick_j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(pick_j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      grant     <= '0;
      spi_cs_n  <= '1;
      rsp_valid <= '0;
      rsp_data  <= '0;
      txn_abort <= '0;
      eng_start <= 1'b0;
      eng_tx    <= '0;
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      txn_abort <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            grant    <= pick_oh;
            spi_cs_n <= ~pick_oh;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_END) begin
            cnt   <= '0;
            state <= S_ISSUE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_ISSUE: begin
          // An accept on the final wait cycle wins over the timeout.
          if (accept) begin
            eng_tx    <= owner_data;
            last_q    <= req_last[owner];
            eng_start <= 1'b1;
            state     <= S_XFER;
          end else if (cnt == TMO_END) begin
            txn_abort <= grant;
            grant     <= '0;
            spi_cs_n  <= '1;
            rr_ptr    <= rr_next;
            cnt       <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_XFER: begin
          if (eng_done) begin
            rsp_valid <= grant;
            rsp_data  <= eng_rx;
            cnt       <= '0;
            if (last_q) begin
              grant    <= '0;
              spi_cs_n <= '1;
              rr_ptr   <= rr_next;
              state    <= S_GAP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
